// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Control-field widths zeroed when a pipeline register loads a bubble
   localparam int unsigned IFID_CTL_W  = 1;
   localparam int unsigned IDEX_CTL_W  = 9;
   localparam int unsigned EXMEM_CTL_W = 5;
   localparam int unsigned MEMWB_CTL_W = 2;

   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd_addr,
      input logic [4:0] id_rs_addr,
      input logic [4:0] id_rt_addr,
      input logic       id_uses_rt
   );
      return ex_mem_read && (ex_rd_addr != REG_ZERO) &&
             ((ex_rd_addr == id_rs_addr) || (id_uses_rt && (ex_rd_addr == id_rt_addr)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory wait > taken branch > load-use, with
// memory-timeout detection and saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs_addr,
   input  logic [4:0]       id_rt_addr,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_addr,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_mem_err;
   logic              w_mem_stall;
   logic              w_load_use;
   logic              w_branch_flush;
   logic              w_wait_inc;
   logic [WAIT_W-1:0] w_wait_cnt;

   assign w_mem_stall    = mem_req && !mem_ready;
   assign w_load_use     = load_use_hazard(ex_mem_read, ex_rd_addr, id_rs_addr,
                                           id_rt_addr, id_uses_rt);
   assign w_branch_flush = !rst && !w_mem_stall && branch_taken;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (w_mem_stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (w_load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_flush  = 1'b1;
      end
   end

   // Withdrawn request or ready both end the wait; only a live stall holds MEM_WAIT
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:      if (w_mem_stall)  w_state_nxt = MEM_WAIT;
         MEM_WAIT: if (!w_mem_stall) w_state_nxt = RUN;
         default:  w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_wait_inc = w_mem_stall && (w_wait_cnt < WAIT_W'(MEM_TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_err <= 1'b0;
      end else if (w_wait_inc && (w_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
         r_mem_err <= 1'b1;
      end
   end

   assign mem_err = r_mem_err;

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (!w_mem_stall),
      .i_inc   (w_wait_inc),
      .o_count (w_wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (1'b0),
      .i_inc   (!pc_en),
      .o_count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (1'b0),
      .i_inc   (w_branch_flush),
      .o_count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   localparam logic [7:0] C_RST   = 8'b00000_111;
   localparam logic [7:0] C_WAIT  = 8'b00001_001;
   localparam logic [7:0] C_BRFL  = 8'b11111_110;
   localparam logic [7:0] C_LU    = 8'b00111_010;
   localparam logic [7:0] C_NORM  = 8'b11111_000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [4:0]    id_rs_addr = '0, id_rt_addr = '0, ex_rd_addr = '0;
   logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
   logic          mem_req = 1'b0, mem_ready = 1'b0;
   logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic          ifid_flush, idex_flush, memwb_flush, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic [7:0]    ctl;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_vec = 0;
   int            n_bad = 0;
   logic [CW-1:0] m_sc = '0, m_fc = '0;
   int unsigned   m_wait = 0;
   logic          m_err = 1'b0;

   task automatic apply(input string tag, input logic r,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
      exp_t       e;
      exp_t       g;
      logic       stall, lu;
      logic [7:0] obs;
      rst = r; id_rs_addr = rs; id_rt_addr = rt; id_uses_rt = urt;
      ex_mem_read = mr; ex_rd_addr = rd; branch_taken = br;
      mem_req = req; mem_ready = rdy;
      if (r) begin
         m_sc = '0; m_fc = '0; m_wait = 0; m_err = 1'b0;
      end
      stall = req && !rdy;
      lu    = mr && (rd != 5'd0) && ((rd == rs) || (urt && (rd == rt)));
      e.tag = tag;
      if (r)          e.ctl = C_RST;
      else if (stall) e.ctl = C_WAIT;
      else if (br)    e.ctl = C_BRFL;
      else if (lu)    e.ctl = C_LU;
      else            e.ctl = C_NORM;
      e.sc = m_sc; e.fc = m_fc; e.err = m_err;
      sb.push_back(e);
      #3;
      g = sb.pop_front();
      n_vec++;
      obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};
      assert (obs === g.ctl) else begin
         n_bad++;
         $error("FAIL %s ctl: got %b expected %b", g.tag, obs, g.ctl);
      end
      assert (stall_cnt === g.sc) else begin
         n_bad++;
         $error("FAIL %s stall_cnt: got %0d expected %0d", g.tag, stall_cnt, g.sc);
      end
      assert (flush_cnt === g.fc) else begin
         n_bad++;
         $error("FAIL %s flush_cnt: got %0d expected %0d", g.tag, flush_cnt, g.fc);
      end
      assert (mem_err === g.err) else begin
         n_bad++;
         $error("FAIL %s mem_err: got %b expected %b", g.tag, mem_err, g.err);
      end
      @(posedge clk);
      #1;
      if (!r) begin
         if (!e.ctl[7] && (m_sc != '1)) m_sc = m_sc + 1'b1;
         if (!stall && br && (m_fc != '1)) m_fc = m_fc + 1'b1;
         if (stall) begin
            if (m_wait < TO) begin
               if (m_wait == TO - 1) m_err = 1'b1;
               m_wait++;
            end
         end else begin
            m_wait = 0;
         end
      end
   endtask

   task automatic quiet(input string tag);
      apply(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mwait(input string tag, input logic br);
      apply(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, br, 1'b1, 1'b0);
   endtask

   initial begin
      #1;
      // reset held three cycles while traffic is present
      for (int i = 0; i < 3; i++)
         apply("reset", 1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      quiet("post_reset");
      quiet("post_reset2");

      apply("lu_rs", 1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      quiet("after_lu");
      apply("lu_rd0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      apply("lu_rt", 1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      apply("rt_unused", 1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      apply("no_load", 1'b0, 5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

      apply("br_vs_lu", 1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      quiet("after_br");

      for (int i = 0; i < 3; i++) mwait("mem_wait", 1'b0);
      apply("mem_ready", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      quiet("after_mem");

      for (int i = 0; i < 2; i++) mwait("br_in_wait", 1'b1);
      apply("br_release", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      quiet("after_br_release");

      for (int i = 0; i < 3; i++) mwait("withdraw_wait", 1'b0);
      quiet("withdrawn");
      quiet("withdrawn2");

      for (int i = 0; i < 6; i++) mwait("timeout_wait", 1'b0);
      apply("timeout_ready", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      quiet("err_sticky");

      for (int i = 0; i < 4; i++)
         apply("lu_sat", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         apply("br_sat", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      quiet("sat_hold");

      apply("reset2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      quiet("err_cleared");
      quiet("err_cleared2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
